// File: rtl/fp_pkg.sv
// Shared sign-magnitude Q-format definitions: default widths, FSM encoding, helper constants.
package fp_pkg;
  localparam int Q_DEF    = 7;
  localparam int N_DEF    = 16;
  localparam int SIGN_BIT = N_DEF - 1;
  localparam logic [N_DEF-2:0] MAG_MAX = '1;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
endpackage

// File: rtl/fp_mul_norm.sv
// Combinational Q-format normalizer: truncate a double-width magnitude, flag overflow,
// optionally saturate (FP_MUL_SAT_EN), and never emit negative zero.
module fp_mul_norm
  import fp_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic [2*(N-1)-1:0] acc,
  input  logic               sign,
  output logic [N-1:0]       c,
  output logic               ovf
);
  logic [N-2:0] mag;
  logic         unused_lsb;

  // Fraction bits below the output LSB are dropped: truncation toward zero.
  assign unused_lsb = ^acc[Q-1:0];

  always_comb begin
    ovf = |acc[2*N-3:N-1+Q];
    mag = acc[N-2+Q:Q];
`ifdef FP_MUL_SAT_EN
    if (ovf) mag = '1;
`endif
    c = {sign && (mag != '0), mag};
  end
endmodule

// File: rtl/fp_mul_seq.sv
// Sequential shift-add sign-magnitude Q-format multiplier, one multiplier bit per clock,
// valid/ready on both sides. Saturation on overflow when FP_MUL_SAT_EN is defined.
module fp_mul_seq
  import fp_pkg::*;
#(
  parameter int Q = Q_DEF,
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] c,
  output logic         ovf,
  output logic         out_valid,
  input  logic         out_ready
);
  localparam int AW = 2*(N-1);
  localparam int CW = (N-1 > 1) ? $clog2(N-1) : 1;

  state_t          state, state_nxt;
  logic [N-2:0]    a_mag, b_sh;
  logic            sign;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    c_n;
  logic            ovf_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid)             state_nxt = MUL;
      MUL:  if (cnt == CW'(N-2))      state_nxt = NORM;
      NORM:                           state_nxt = DONE;
      DONE: if (out_ready)            state_nxt = IDLE;
      default:                        state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  fp_mul_norm #(.Q(Q), .N(N)) u_norm (
    .acc  (acc),
    .sign (sign),
    .c    (c_n),
    .ovf  (ovf_n)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_mag <= '0;
      b_sh  <= '0;
      sign  <= 1'b0;
      acc   <= '0;
      cnt   <= '0;
      c     <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_mag <= a_in[N-2:0];
          b_sh  <= b_in[N-2:0];
          sign  <= a_in[N-1] ^ b_in[N-1];
          acc   <= '0;
          cnt   <= '0;
        end
        MUL: begin
          if (b_sh[0]) acc <= acc + (AW'(a_mag) << cnt);
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
        end
        // c/ovf only change here, so they hold through DONE until the transfer.
        NORM: begin
          c   <= c_n;
          ovf <= ovf_n;
        end
        default: ;
      endcase
    end
  end
endmodule
